// File: rtl/regfile_pkg.sv
// Shared widths and controller state encoding for the register-file controller slice.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_COUNT  = 32;

    typedef enum logic {
        RF_CLEAR,
        RF_RUN
    } rf_state_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered operand port: x0 zeroing, same-cycle write bypass, operand register.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_W,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] rf_do,
    input  logic                  byp_we,
    input  logic [ADDR_WIDTH-1:0] byp_addr,
    input  logic [DATA_WIDTH-1:0] byp_data,
    output logic [DATA_WIDTH-1:0] data
);

    logic [DATA_WIDTH-1:0] operand;

    // byp_we already excludes x0, so the address-zero check only guards the RAM path.
    always_comb begin
        operand = rf_do;
        if (addr == '0) begin
            operand = '0;
        end else if (byp_we && (byp_addr == addr)) begin
            operand = byp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (run && rd_en) begin
            data <= operand;
        end
    end

endmodule

// File: rtl/regfile_ctrl.sv
// Register-file controller: clears both distributed RAMs after reset, guards x0,
// and presents registered, write-bypassed rs1/rs2 operands with a valid strobe.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RF_CLEAR | walking clr_cnt over every entry, writing zero; CPU ignored
//   RF_RUN   | ready; CPU writes go to RAM, reads captured into operands
module regfile_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_W,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    output logic                  rd_valid,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_di,
    output logic [ADDR_WIDTH-1:0] rf1_raddr,
    output logic [ADDR_WIDTH-1:0] rf2_raddr,
    input  logic [DATA_WIDTH-1:0] rf1_do,
    input  logic [DATA_WIDTH-1:0] rf2_do
);

    rf_state_t             state, state_nxt;
    logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;
    logic                  run;
    logic                  cpu_we;

    assign run       = (state == RF_RUN);
    assign cpu_we    = wr_en && (wr_addr != '0);
    assign rf1_raddr = rs1_addr;
    assign rf2_raddr = rs2_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RF_CLEAR;
            clr_cnt  <= '0;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            clr_cnt  <= clr_cnt_nxt;
            rd_valid <= run && rd_en;
        end
    end

    // rst gates the RAM write and ready so nothing leaks out in the cycle reset is applied.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        ready       = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = wr_addr;
        rf_di       = wr_data;
        case (state)
            RF_CLEAR: begin
                rf_we       = !rst;
                rf_waddr    = clr_cnt;
                rf_di       = '0;
                clr_cnt_nxt = clr_cnt + ADDR_WIDTH'(1);
                if (clr_cnt == {ADDR_WIDTH{1'b1}}) begin
                    state_nxt = RF_RUN;
                end
            end
            RF_RUN: begin
                ready = !rst;
                rf_we = cpu_we && !rst;
            end
            default: state_nxt = RF_CLEAR;
        endcase
    end

    regfile_rd_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rd_port1 (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .rd_en    (rd_en),
        .addr     (rs1_addr),
        .rf_do    (rf1_do),
        .byp_we   (cpu_we),
        .byp_addr (wr_addr),
        .byp_data (wr_data),
        .data     (rs1_data)
    );

    regfile_rd_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rd_port2 (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .rd_en    (rd_en),
        .addr     (rs2_addr),
        .rf_do    (rf2_do),
        .byp_we   (cpu_we),
        .byp_addr (wr_addr),
        .byp_data (wr_data),
        .data     (rs2_data)
    );

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl: behavioural RAM pair plus an architectural register model.
module tb_regfile_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        rd_valid;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_di;
    logic [4:0]  rf1_raddr, rf2_raddr;
    logic [31:0] rf1_do, rf2_do;

    int total = 0;
    int bad   = 0;

    logic [31:0] ram [32];
    logic [31:0] ref_rf [32];
    logic [31:0] exp_rs1, exp_rs2;

    always #5 clk = ~clk;

    regfile_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .rd_valid  (rd_valid),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_di     (rf_di),
        .rf1_raddr (rf1_raddr),
        .rf2_raddr (rf2_raddr),
        .rf1_do    (rf1_do),
        .rf2_do    (rf2_do)
    );

    // Both RAMs see the same write port, so one array stands in for the pair.
    always @(posedge clk) if (rf_we) ram[rf_waddr] <= rf_di;
    assign rf1_do = ram[rf1_raddr];
    assign rf2_do = ram[rf2_raddr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rs1_addr = '0; rs2_addr = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (we && wa == a) return wd;
        return ref_rf[a];
    endfunction

    // One RUN cycle: drive, check the RAM write port, clock, check the operands.
    task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re, input logic [4:0] a1, input logic [4:0] a2);
        logic exp_we;
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en = re; rs1_addr = a1; rs2_addr = a2;
        #1;
        exp_we = we && (wa != 5'd0);
        check("rf_we", {31'd0, rf_we}, {31'd0, exp_we});
        check("rf1_raddr", {27'd0, rf1_raddr}, {27'd0, a1});
        check("rf2_raddr", {27'd0, rf2_raddr}, {27'd0, a2});
        if (exp_we) begin
            check("rf_waddr", {27'd0, rf_waddr}, {27'd0, wa});
            check("rf_di", rf_di, wd);
        end
        if (re) begin
            exp_rs1 = model_read(a1, we, wa, wd);
            exp_rs2 = model_read(a2, we, wa, wd);
        end
        if (exp_we) ref_rf[wa] = wd;
        @(posedge clk);
        #1;
        check("rd_valid", {31'd0, rd_valid}, {31'd0, re});
        check("rs1_data", rs1_data, exp_rs1);
        check("rs2_data", rs2_data, exp_rs2);
        idle_inputs();
    endtask

    // Walks n clear cycles starting from entry 0; optionally pokes CPU requests at cycle 10.
    task automatic run_clear(input int n, input bit poke);
        for (int i = 0; i < n; i++) begin
            if (poke && i == 10) begin
                wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hFF;
                rd_en = 1'b1; rs1_addr = 5'd3; rs2_addr = 5'd3;
            end
            #1;
            check("clr_we", {31'd0, rf_we}, 32'd1);
            check("clr_waddr", {27'd0, rf_waddr}, i);
            check("clr_di", rf_di, 32'd0);
            check("clr_ready", {31'd0, ready}, 32'd0);
            @(posedge clk);
            #1;
            idle_inputs();
            check("clr_rd_valid", {31'd0, rd_valid}, 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            ram[i]    = $urandom;
            ref_rf[i] = 32'd0;
        end
        exp_rs1 = '0;
        exp_rs2 = '0;
        idle_inputs();
        rst = 1'b1;
        tick(); tick(); tick();

        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_rs1", rs1_data, 32'd0);
        check("rst_rs2", rs2_data, 32'd0);
        check("rst_rf_we", {31'd0, rf_we}, 32'd0);

        // Reset release with CPU requests poked mid-clear.
        rst = 1'b0;
        run_clear(32, 1'b1);
        check("ready_after_clear", {31'd0, ready}, 32'd1);
        for (int i = 0; i < 32; i++) begin
            cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 5'(31 - i));
            check("cleared_rs1", rs1_data, 32'd0);
        end

        // Basic write then read.
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0);
        check("x5_rs1", rs1_data, 32'hDEADBEEF);
        check("x5_rs2", rs2_data, 32'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd1, 5'd2);
        check("hold_rs1", rs1_data, 32'hDEADBEEF);

        // x0 protection.
        cycle(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
        check("x0_rs1", rs1_data, 32'd0);

        // Bypass over stale RAM contents, then RAM read one cycle later.
        cycle(1'b1, 5'd7, 32'h11111111, 1'b0, 5'd0, 5'd0);
        cycle(1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd7, 5'd7);
        check("byp_rs1", rs1_data, 32'hA5A5A5A5);
        check("byp_rs2", rs2_data, 32'hA5A5A5A5);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7);
        check("after_byp_rs1", rs1_data, 32'hA5A5A5A5);

        // Reset mid-clear at clr_cnt=20.
        rst = 1'b1;
        #1;
        check("rst_run_rf_we", {31'd0, rf_we}, 32'd0);
        tick();
        rst = 1'b0;
        run_clear(20, 1'b0);
        #1;
        check("mid_waddr", {27'd0, rf_waddr}, 32'd20);
        rst = 1'b1;
        #1;
        check("mid_rst_rf_we", {31'd0, rf_we}, 32'd0);
        tick();
        check("mid_rst_ready", {31'd0, ready}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
        exp_rs1 = '0;
        exp_rs2 = '0;
        run_clear(32, 1'b0);
        check("ready_after_reclear", {31'd0, ready}, 32'd1);

        // Randomized traffic against the architectural model.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa, a1, a2;
            wa = 5'($urandom_range(0, 31));
            a1 = 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0) a1 = wa;
            cycle(1'($urandom), wa, $urandom, 1'($urandom), a1, a2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout: bench exceeded time limit");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
